// File: rtl/sram_bus_fifo_if.sv
// sram_bus_fifo_if: CPU register bus strobes plus the fabric drain stream and irq
interface sram_bus_fifo_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic          bus_wr_stb;
    logic          bus_rd_stb;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          irq;
    modport master (
        output bus_wr_stb, bus_rd_stb, bus_addr, bus_wdata, m_ready,
        input  bus_rdata, m_data, m_valid, irq
    );
    modport slave (
        input  bus_wr_stb, bus_rd_stb, bus_addr, bus_wdata, m_ready,
        output bus_rdata, m_data, m_valid, irq
    );
endinterface

// File: rtl/sram_bus_fifo.sv
// sram_bus_fifo: CPU write mailbox FIFO with status/control registers and low-water irq
module sram_bus_fifo #(
    parameter int DW         = 16,
    parameter int AW         = 10,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_bus_fifo_if.slave        bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic [7:0]            thresh_q, thresh_d;
    logic [DW-1:0]         rdata_q, rdata_d, rd_val;
    logic [1:0]            sel;
    logic                  wr_data, wr_ctrl, wr_thr, flush, clr_ovf;
    logic                  full, empty, pop, push_ok, ovf_set;
    logic                  unused_addr;

    assign unused_addr = ^bus.bus_addr[AW-1:2];
    assign sel         = bus.bus_addr[1:0];
    assign wr_data     = bus.bus_wr_stb && sel == 2'd0;
    assign wr_ctrl     = bus.bus_wr_stb && sel == 2'd2;
    assign wr_thr      = bus.bus_wr_stb && sel == 2'd3;
    assign flush       = wr_ctrl && bus.bus_wdata[0];
    assign clr_ovf     = wr_ctrl && bus.bus_wdata[1];
    assign full        = count_q == (DEPTH_LOG2+1)'(DEPTH);
    assign empty       = count_q == '0;
    assign pop         = !empty && bus.m_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands
    assign push_ok     = wr_data && (!full || pop);
    assign ovf_set     = wr_data && full && !pop;

    assign bus.m_data    = mem_q[rptr_q];
    assign bus.m_valid   = !empty;
    assign bus.bus_rdata = rdata_q;
    assign bus.irq       = irq_q;

    // Next-state for pointers, count, control registers and registered read data
    always_comb begin
        wptr_d   = flush ? '0 : push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d   = flush ? '0 : pop ? rptr_q + 1'b1 : rptr_q;
        count_d  = flush ? '0 : count_q + {{DEPTH_LOG2{1'b0}}, push_ok} - {{DEPTH_LOG2{1'b0}}, pop};
        ovf_d    = ovf_set || (ovf_q && !clr_ovf);
        irq_en_d = wr_ctrl ? bus.bus_wdata[2] : irq_en_q;
        thresh_d = wr_thr ? bus.bus_wdata[7:0] : thresh_q;
        rd_val   = sel == 2'd1 ? DW'({ovf_q, full, empty, 5'b0, 8'(count_q)}) :
                   sel == 2'd2 ? DW'({irq_en_q, 2'b0}) :
                   sel == 2'd3 ? DW'(thresh_q) : '0;
        rdata_d  = bus.bus_rd_stb && !bus.bus_wr_stb ? rd_val : rdata_q;
        irq_d    = irq_en_q && (8'(count_q) <= thresh_q);
    end

    // Control and status state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wptr_q] <= bus.bus_wdata;
    end
endmodule
